// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI byte parser: FSM states, status
// nibbles/bytes and the data-length helper for channel messages.
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NOTE_D1,
    NOTE_D2,
    SKIP_D1,
    SKIP_D2
  } state_t;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] PROG_CHG   = 4'hC;
  localparam logic [3:0] CHAN_PRESS = 4'hD;
  localparam logic [7:0] SYSEX      = 8'hF0;
  localparam logic [7:0] RT_MIN     = 8'hF8;

  // Number of data bytes following a channel-voice status nibble.
  function automatic logic [1:0] data_len(input logic [3:0] status_nibble);
    return ((status_nibble == PROG_CHG) || (status_nibble == CHAN_PRESS)) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// Single-clock MIDI byte parser: turns the SPI receive byte stream into
// note on/off events, with running status, channel filter and back-pressure.
module midi_byte_parser
  import midi_pkg::*;
#(
  parameter int unsigned CHANNEL = 0,
  parameter bit          OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_on,
  output logic [6:0] ev_note,
  output logic [6:0] ev_velocity,
  output logic [7:0] running_status,
  output logic [7:0] drop_count
);

  state_t     state;
  logic [6:0] note_q;
  logic       byte_fire;
  logic [3:0] in_hi;
  logic       chan_ok;

  // The output register is the only buffer: a byte may only be taken when
  // the event slot is empty or being drained this same cycle.
  assign in_ready  = !ev_valid || ev_ready;
  assign byte_fire = in_valid && in_ready;
  assign in_hi     = in_data[7:4];
  assign chan_ok   = OMNI || (in_data[3:0] == CHANNEL[3:0]);

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so later assignments in the same cycle (e.g. a new event) cleanly override
  // earlier ones (the event drain) without ordering races.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      note_q         <= '0;
      running_status <= '0;
      ev_valid       <= 1'b0;
      ev_on          <= 1'b0;
      ev_note        <= '0;
      ev_velocity    <= '0;
      drop_count     <= '0;
    end else begin
      if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end

      // Real-time bytes are accepted but otherwise invisible to the parser.
      if (byte_fire && (in_data < RT_MIN)) begin
        if (in_data[7]) begin
          if (in_data >= SYSEX) begin
            running_status <= '0;
            state          <= IDLE;
          end else if (((in_hi == NOTE_OFF) || (in_hi == NOTE_ON)) && chan_ok) begin
            running_status <= in_data;
            state          <= NOTE_D1;
          end else begin
            running_status <= '0;
            state          <= (data_len(in_hi) == 2'd1) ? SKIP_D2 : SKIP_D1;
          end
        end else begin
          case (state)
            IDLE: begin
              if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
              end
            end
            NOTE_D1: begin
              note_q <= in_data[6:0];
              state  <= NOTE_D2;
            end
            NOTE_D2: begin
              ev_valid <= 1'b1;
              ev_note  <= note_q;
              if ((running_status[7:4] == NOTE_ON) && (in_data[6:0] != 7'd0)) begin
                ev_on       <= 1'b1;
                ev_velocity <= in_data[6:0];
              end else begin
                ev_on       <= 1'b0;
                ev_velocity <= '0;
              end
              state <= NOTE_D1;
            end
            SKIP_D1: state <= SKIP_D2;
            SKIP_D2: state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_byte_parser.sv
// Self-checking bench for midi_byte_parser: directed scenarios plus random
// byte streams checked against a message-level reference model.
module tb_midi_byte_parser;

  logic       clk;
  logic       nreset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_on;
  logic [6:0] ev_note;
  logic [6:0] ev_velocity;
  logic [7:0] running_status;
  logic [7:0] drop_count;

  midi_byte_parser #(.CHANNEL(0), .OMNI(1'b0)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_on          (ev_on),
    .ev_note        (ev_note),
    .ev_velocity    (ev_velocity),
    .running_status (running_status),
    .drop_count     (drop_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: tracks the current message as a status plus a list of
  // collected data bytes, and emits events into a queue.
  typedef struct {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
  } ev_t;

  ev_t        exp_q[$];
  logic [6:0] m_buf[$];
  logic [7:0] m_rs;
  int         m_need;
  bit         m_note;
  int         m_drops;

  task automatic model_reset();
    exp_q.delete();
    m_buf.delete();
    m_rs    = 8'h00;
    m_need  = 0;
    m_note  = 1'b0;
    m_drops = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int hi;
    ev_t e;
    hi = int'(b) / 16;
    if (b >= 8'hF8) return;
    if (b >= 8'h80) begin
      m_buf.delete();
      if ((hi == 8 || hi == 9) && (int'(b) % 16 == 0)) begin
        m_rs = b; m_need = 2; m_note = 1'b1;
      end else if (hi <= 14) begin
        m_rs = 8'h00; m_note = 1'b0;
        m_need = (hi == 12 || hi == 13) ? 1 : 2;
      end else begin
        m_rs = 8'h00; m_note = 1'b0; m_need = 0;
      end
    end else if (m_need == 0) begin
      if (m_drops < 255) m_drops++;
    end else begin
      m_buf.push_back(b[6:0]);
      if (m_buf.size() == m_need) begin
        if (m_note) begin
          e.note = m_buf[0];
          e.on   = (hi_of(m_rs) == 9) && (m_buf[1] != 7'd0);
          e.vel  = e.on ? m_buf[1] : 7'd0;
          exp_q.push_back(e);
        end else begin
          m_need = 0;
        end
        m_buf.delete();
      end
    end
  endtask

  function automatic int hi_of(input logic [7:0] s);
    return int'(s) / 16;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ev_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ev_ready = 1'b0;
        1:       ev_ready = 1'b1;
        default: ev_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Continuous checking: registered outputs against the model state, then
  // advance the model with whatever transfers happen at the next edge.
  always @(negedge clk) begin
    if (nreset) begin
      check("ev_valid", ev_valid, exp_q.size() != 0);
      if (ev_valid && exp_q.size() != 0) begin
        check("ev_on", ev_on, exp_q[0].on);
        check("ev_note", ev_note, exp_q[0].note);
        check("ev_velocity", ev_velocity, exp_q[0].vel);
      end
      check("running_status", running_status, m_rs);
      check("drop_count", drop_count, m_drops);
      check("in_ready", in_ready, !ev_valid || ev_ready);
      if (ev_valid && ev_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) model_byte(in_data);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_event(input string tag, input logic on, input logic [6:0] note,
                             input logic [6:0] vel);
    check({tag, "_valid"}, ev_valid, 1'b1);
    check({tag, "_on"}, ev_on, on);
    check({tag, "_note"}, ev_note, note);
    check({tag, "_vel"}, ev_velocity, vel);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ev_valid"}, ev_valid, 1'b0);
    check({tag, "_ev_on"}, ev_on, 1'b0);
    check({tag, "_ev_note"}, ev_note, 7'd0);
    check({tag, "_ev_vel"}, ev_velocity, 7'd0);
    check({tag, "_rs"}, running_status, 8'h00);
    check({tag, "_drops"}, drop_count, 8'd0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int r;
    logic [7:0] b;
    logic [3:0] ch;

    nreset   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    nreset = 1'b1;
    idle_cycles(2);

    // Basic note-on, event visible one cycle after the velocity byte.
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    check_event("note_on", 1'b1, 7'h45, 7'h64);
    check("note_on_rs", running_status, 8'h90);
    idle_cycles(2);

    // Running status with velocity-0 note-off.
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40);
    check_event("rs_first", 1'b1, 7'h3C, 7'h40);
    send_byte(8'h40); send_byte(8'h00);
    check_event("rs_vel0", 1'b0, 7'h40, 7'h00);
    idle_cycles(2);

    // Real-time bytes interleaved inside a message.
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h30); send_byte(8'hFE); send_byte(8'h50);
    check_event("realtime", 1'b1, 7'h30, 7'h50);
    idle_cycles(2);

    // Other channel, then program change plus one stray byte.
    send_byte(8'h91); send_byte(8'h30); send_byte(8'h50);
    idle_cycles(1);
    check("filter_no_event", ev_valid, 1'b0);
    check("filter_rs", running_status, 8'h00);
    send_byte(8'hC0); send_byte(8'h05); send_byte(8'h22);
    idle_cycles(1);
    check("stray_drop", drop_count, 8'd1);
    check("stray_no_event", ev_valid, 1'b0);

    // Back-pressure: the second message stalls behind the held event.
    ready_mode = 0;
    idle_cycles(1);
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h10);
    idle_cycles(2);
    check_event("bp_held", 1'b0, 7'h3C, 7'h00);
    check("bp_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h90;
    idle_cycles(3);
    check("bp_stalled_ready", in_ready, 1'b0);
    check("bp_stalled_rs", running_status, 8'h80);
    ready_mode = 1;
    send_byte(8'h90); send_byte(8'h3E); send_byte(8'h20);
    check_event("bp_second", 1'b1, 7'h3E, 7'h20);
    idle_cycles(2);

    // Reset in the middle of a message.
    send_byte(8'h90); send_byte(8'h40);
    #2;
    nreset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    @(posedge clk);
    #1;
    nreset = 1'b1;
    send_byte(8'h50);
    idle_cycles(1);
    check("post_reset_drop", drop_count, 8'd1);
    check("post_reset_no_event", ev_valid, 1'b0);

    // Random streams with random consumer back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        idle_cycles(1);
      end else if (r < 18) begin
        send_byte(8'($urandom_range(8'hF8, 8'hFF)));
      end else if (r < 40) begin
        ch = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        case ($urandom_range(0, 5))
          0, 1:    b = {4'h9, ch};
          2:       b = {4'h8, ch};
          3, 4:    b = {4'($urandom_range(10, 14)), ch};
          default: b = 8'($urandom_range(8'hF0, 8'hF7));
        endcase
        send_byte(b);
      end else begin
        b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
        send_byte(b);
      end
    end
    ready_mode = 1;
    idle_cycles(4);

    // Drop counter saturation during SysEx.
    send_byte(8'hF0);
    for (int i = 0; i < 260; i++) send_byte(8'h11);
    idle_cycles(1);
    check("drop_saturate", drop_count, 8'hFF);
    check("sat_no_event", ev_valid, 1'b0);

    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/midi_byte_parser.md
Name: midi_byte_parser

Overview:
- Sits directly upstream of the DDS voice core, between the SPI slave's receive byte stream and the note/frequency logic.
- Converts raw MIDI bytes into clean note events: note number, velocity, on/off.
- Handles running status, velocity-0 note-off, channel filtering, system real-time bytes and stray data bytes.
- Replaces ad-hoc byte counting on a data-valid edge with a single-clock, back-pressured parser.

Parameters:
- CHANNEL, 0, MIDI channel accepted (0-15); status low nibble must match.
- OMNI, 0, 1 = accept all channels and ignore CHANNEL.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- in_valid  in  1  byte from SPI receive stream is valid
- in_data  in  8  received MIDI byte
- in_ready  out  1  parser can accept a byte this cycle
- ev_valid  out  1  note event pending
- ev_ready  in  1  consumer accepts event
- ev_on  out  1  1 = note on, 0 = note off
- ev_note  out  7  MIDI note number
- ev_velocity  out  7  velocity; 0 on note-off events
- running_status  out  8  current running status (0x00 = none), debug/LED
- drop_count  out  8  saturating count of discarded data bytes

Behaviour:
- Reset (async assert, sync release): state IDLE; running_status=0; ev_valid=0; ev_on=0; ev_note=0; ev_velocity=0; drop_count=0; in_ready=1.
- Byte transfer occurs when in_valid && in_ready. Event transfer occurs when ev_valid && ev_ready.
- in_ready = !ev_valid || ev_ready. The single output register is the only buffer; no byte is ever lost under back-pressure.
- States:
  - IDLE: no running status.
  - NOTE_D1: expecting note byte.
  - NOTE_D2: expecting velocity byte.
  - SKIP_D1: discarding first data byte of a non-note message.
  - SKIP_D2: discarding second data byte.
- Real-time bytes 0xF8-0xFF: consumed in any state; no state, running-status or counter change.
- Status 0x80-0x9F:
  - Channel match (or OMNI): latch running_status, go to NOTE_D1.
  - Channel mismatch: running_status=0, go to SKIP_D1 with 2-byte skip.
- Status 0xA0-0xEF: running_status=0; skip 2 data bytes, except 0xC0-0xDF which skip 1.
- Status 0xF0-0xF7: running_status=0, go to IDLE. SysEx data bytes are dropped as stray bytes.
- Any status byte arriving mid-message aborts that message with no event, then is processed normally.
- Data byte (bit7=0) handling:
  - IDLE: drop it; drop_count++ (saturates at 255).
  - NOTE_D1: latch note, go to NOTE_D2.
  - NOTE_D2: emit event, go back to NOTE_D1 (running status).
  - SKIP states: discard; after the last skipped byte return to IDLE.
- Event composition on the velocity byte:
  - 0x9n with velocity>0 gives ev_on=1 and ev_velocity=vel.
  - 0x9n with velocity=0, or 0x8n with any velocity, gives ev_on=0 and ev_velocity=0.
- Latency: ev_valid rises the cycle after the velocity byte is accepted. Event fields stay stable while ev_valid=1 && !ev_ready.
- Simultaneous accept: if ev_ready=1 and a completing velocity byte arrives the same cycle, the new event replaces the old one with no bubble, so ev_valid stays 1.
- Reset mid-message or mid-event: everything clears immediately and the pending event is lost.

Decomposition:
- Package midi_pkg holds:
  - State enum.
  - Status constants: NOTE_OFF=0x8, NOTE_ON=0x9, PROG_CHG=0xC, CHAN_PRESS=0xD, SYSEX=0xF0, RT_MIN=0xF8.
  - Helper function data_len(status_nibble) returning 1 or 2.
- No sub-module needed; the parser is a single FSM plus one output register.

Test Plan:
- 0x90,0x45,0x64 with ev_ready=1 -> one event on=1, note=0x45, vel=0x64, one cycle after the 3rd byte; running_status=0x90.
- Running status: 0x90,0x3C,0x40,0x40,0x00 -> two events: (on, 0x3C, 0x40), then (off, 0x40, 0).
- Real-time interleave: 0x90,0xF8,0x30,0xFE,0x50 -> single event (on, 0x30, 0x50); 0xF8/0xFE consumed, state unaffected.
- Filtering and stray bytes, CHANNEL=0, OMNI=0:
  - 0x91,0x30,0x50 -> no event.
  - 0xC0,0x05 then 0x22 -> no event; drop_count=1 (0x22 stray in IDLE).
- Back-pressure: hold ev_ready=0, send 0x80,0x3C,0x10 then 0x90,0x3E,0x20:
  - in_ready goes 0 after the first event and the 2nd message stalls.
  - Release ev_ready -> events (off, 0x3C, 0) then (on, 0x3E, 0x20) in order; no bytes lost.
- Reset mid-message: 0x90,0x40, assert nreset=0 -> outputs at reset values immediately. After release, 0x50 is a stray byte, giving drop_count=1 and no event.
